// File: rtl/alu_issue_ctrl.sv
// Command/response front end for the registered ALU: holds operands stable across the ALU
// latency, captures result and flags, and adds compare conditions for branch logic.
module alu_issue_ctrl #(
  parameter int unsigned NUMBITS = 16,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [NUMBITS-1:0] cmd_a,
  input  logic [NUMBITS-1:0] cmd_b,
  input  logic [TAGW-1:0]    cmd_tag,
  output logic [NUMBITS-1:0] alu_A,
  output logic [NUMBITS-1:0] alu_B,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [NUMBITS-1:0] rsp_result,
  output logic               rsp_carry,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic               rsp_neg,
  output logic               rsp_lt_u,
  output logic               rsp_lt_s,
  output logic [TAGW-1:0]    rsp_tag,
  output logic [15:0]        op_count
);

  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] LatCnt = CntW'(ALU_LAT);
  localparam logic [2:0] OpUsub = 3'b010;
  localparam logic [2:0] OpSsub = 3'b011;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [NUMBITS-1:0]  alu_a_q, alu_a_d;
  logic [NUMBITS-1:0]  alu_b_q, alu_b_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic [TAGW-1:0]     tag_q, tag_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [NUMBITS-1:0]  rsp_result_q, rsp_result_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_overflow_q, rsp_overflow_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_neg_q, rsp_neg_d;
  logic                rsp_lt_u_q, rsp_lt_u_d;
  logic                rsp_lt_s_q, rsp_lt_s_d;
  logic [TAGW-1:0]     rsp_tag_q, rsp_tag_d;
  logic [15:0]         op_count_q, op_count_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cmd_ready_d    = cmd_ready_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    tag_d          = tag_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_neg_d      = rsp_neg_q;
    rsp_lt_u_d     = rsp_lt_u_q;
    rsp_lt_s_d     = rsp_lt_s_q;
    rsp_tag_d      = rsp_tag_q;
    op_count_d     = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          alu_a_d     = cmd_a;
          alu_b_d     = cmd_b;
          alu_op_d    = cmd_op;
          tag_d       = cmd_tag;
          cnt_d       = LatCnt;
          cmd_ready_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // ALU outputs have settled from the operands held since accept.
          rsp_result_d   = alu_result;
          rsp_carry_d    = alu_carryout;
          rsp_overflow_d = alu_overflow;
          rsp_zero_d     = alu_zero;
          rsp_neg_d      = alu_result[NUMBITS-1];
          rsp_lt_u_d     = (alu_op_q == OpUsub) & alu_carryout;
          rsp_lt_s_d     = (alu_op_q == OpSsub) & (alu_result[NUMBITS-1] ^ alu_overflow);
          rsp_tag_d      = tag_q;
          rsp_valid_d    = 1'b1;
          state_d        = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      cmd_ready_q    <= 1'b1;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      tag_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_neg_q      <= 1'b0;
      rsp_lt_u_q     <= 1'b0;
      rsp_lt_s_q     <= 1'b0;
      rsp_tag_q      <= '0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_ready_q    <= cmd_ready_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      tag_q          <= tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_neg_q      <= rsp_neg_d;
      rsp_lt_u_q     <= rsp_lt_u_d;
      rsp_lt_s_q     <= rsp_lt_s_d;
      rsp_tag_q      <= rsp_tag_d;
      op_count_q     <= op_count_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign alu_A        = alu_a_q;
  assign alu_B        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_neg      = rsp_neg_q;
  assign rsp_lt_u     = rsp_lt_u_q;
  assign rsp_lt_s     = rsp_lt_s_q;
  assign rsp_tag      = rsp_tag_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a registered ALU stand-in plus an arithmetic reference model
// check directed and randomized operations, backpressure, mid-flight reset and throughput.
module tb_alu_issue_ctrl;

  localparam int N   = 16;
  localparam int TW  = 4;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [N-1:0]  cmd_a, cmd_b;
  logic [TW-1:0] cmd_tag;
  logic [N-1:0]  alu_A, alu_B;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_result;
  logic          alu_carryout, alu_overflow, alu_zero;
  logic          rsp_valid, rsp_ready;
  logic [N-1:0]  rsp_result;
  logic          rsp_carry, rsp_overflow, rsp_zero, rsp_neg, rsp_lt_u, rsp_lt_s;
  logic [TW-1:0] rsp_tag;
  logic [15:0]   op_count;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NUMBITS(N), .TAGW(TW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_neg(rsp_neg), .rsp_lt_u(rsp_lt_u), .rsp_lt_s(rsp_lt_s),
    .rsp_tag(rsp_tag), .op_count(op_count)
  );

  // Registered ALU stand-in: no reset, no enable, LAT register stages.
  function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
      3'd1: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd2: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; end
      3'd3: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a >> 1;
    endcase
    return {c, v, (r == 16'd0), r};
  endfunction

  logic [18:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_opcode, alu_A, alu_B);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {alu_carryout, alu_overflow, alu_zero, alu_result} = pipe[LAT-1];

  // Reference: integer arithmetic and plain comparisons, packed like obs().
  function automatic logic [25:0] ref_rsp(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] tag);
    int ua, ub, sa, sb, s;
    logic [15:0] r;
    logic c, v, lu, ls;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (op)
      3'd0: begin s = ua + ub; r = 16'(s); c = (s > 65535); end
      3'd1: begin s = sa + sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd2: begin s = ua - ub; r = 16'(s); c = (ua < ub); end
      3'd3: begin s = sa - sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 16'(ua / 2);
    endcase
    lu = (op == 3'd2) && (ua < ub);
    ls = (op == 3'd3) && (sa < sb);
    return {r, c, v, (r == 16'd0), r[15], lu, ls, tag};
  endfunction

  function automatic logic [25:0] obs();
    return {rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_neg, rsp_lt_u, rsp_lt_s, rsp_tag};
  endfunction

  // Stimulus helpers: called at a negedge, return at a negedge; no checking inside.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic complete();
    logic hs;
    hs = rsp_valid;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (hs) exp_count = exp_count + 16'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 16'd0;
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_hs got rdy/vld=%b want=10", {cmd_ready, rsp_valid});
    end
    total++;
    if ({alu_A, alu_B, alu_opcode} !== 35'd0) begin
      bad++; $display("FAIL reset_alu got A=%h B=%h op=%h want 0", alu_A, alu_B, alu_opcode);
    end
    total++;
    if (obs() !== 26'd0 || op_count !== 16'd0) begin
      bad++; $display("FAIL reset_rsp got rsp=%h cnt=%h want 0", obs(), op_count);
    end
  endtask

  task automatic test_uadd();
    int e;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL uadd_ready got=%b want=1", cmd_ready); end
    send(3'd0, 16'hFFFF, 16'h0001, 4'd3);
    wait_rsp(e);
    total++;
    if (e !== LAT + 1) begin bad++; $display("FAIL uadd_latency got=%0d want=%0d", e, LAT + 1); end
    total++;
    if (obs() !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3}) begin
      bad++; $display("FAIL uadd_rsp got=%h want=%h", obs(),
                      {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3});
    end
    complete();
    total++;
    if (op_count !== 16'd1) begin bad++; $display("FAIL uadd_count got=%0d want=1", op_count); end
  endtask

  task automatic test_sadd();
    int e;
    send(3'd1, 16'h7FFF, 16'h0001, 4'd9);
    wait_rsp(e);
    total++;
    if (obs() !== {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9}) begin
      bad++; $display("FAIL sadd_rsp got=%h want=%h", obs(),
                      {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9});
    end
    complete();
  endtask

  task automatic test_sub();
    int e;
    send(3'd2, 16'h0003, 16'h0005, 4'd1);
    wait_rsp(e);
    total++;
    if (obs() !== {16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1}) begin
      bad++; $display("FAIL usub_rsp got=%h want=%h", obs(),
                      {16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1});
    end
    complete();
    send(3'd3, 16'h8000, 16'h0001, 4'd2);
    wait_rsp(e);
    total++;
    if (obs() !== {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2}) begin
      bad++; $display("FAIL ssub_rsp got=%h want=%h", obs(),
                      {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2});
    end
    complete();
  endtask

  task automatic test_backpressure();
    int e;
    send(3'd6, 16'h00FF, 16'h0F0F, 4'd5);
    wait_rsp(e);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_a     = 16'hAAAA;
    cmd_b     = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_result, cmd_ready, alu_A} !== {1'b1, 16'h0FF0, 1'b0, 16'h00FF}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got vld=%b res=%h rdy=%b A=%h want 1 0ff0 0 00ff",
                        i, rsp_valid, rsp_result, cmd_ready, alu_A);
      end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    complete();
    total++;
    if (op_count !== exp_count) begin
      bad++; $display("FAIL bp_count got=%0d want=%0d", op_count, exp_count);
    end
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL bp_release got rdy/vld=%b want=10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    send(3'd0, 16'h1234, 16'h1111, 4'd7);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 16'd0;
    total++;
    if ({rsp_valid, cmd_ready, alu_A, op_count} !== {1'b0, 1'b1, 16'h0, 16'h0}) begin
      bad++; $display("FAIL midreset got vld=%b rdy=%b A=%h cnt=%h want 0 1 0 0",
                      rsp_valid, cmd_ready, alu_A, op_count);
    end
    seen = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    rsp_ready = 1'b0;
    total++;
    if (seen !== 1'b0 || op_count !== 16'd0) begin
      bad++; $display("FAIL midreset_drop got seen=%b cnt=%0d want 0 0", seen, op_count);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, n_rsp;
    int acc_cyc [2];
    logic [15:0] rres [2];
    logic rz [2];
    n_acc = 0;
    n_rsp = 0;
    for (int k = 0; k < 2; k++) begin acc_cyc[k] = 0; rres[k] = 'x; rz[k] = 1'bx; end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    cmd_a     = 16'h0001;
    cmd_b     = 16'h0000;
    cmd_tag   = 4'd4;
    for (int cyc = 0; cyc < 40 && n_rsp < 2; cyc++) begin
      if (rsp_valid && n_rsp < 2) begin
        rres[n_rsp] = rsp_result;
        rz[n_rsp]   = rsp_zero;
        n_rsp++;
        exp_count = exp_count + 16'd1;
      end
      if (cmd_valid && cmd_ready && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk);
      @(negedge clk);
      if (n_acc == 1) begin
        cmd_op = 3'd4; cmd_a = 16'hF0F0; cmd_b = 16'h0FF0; cmd_tag = 4'd8;
      end
      if (n_acc == 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    total++;
    if (n_rsp !== 2 || n_acc !== 2) begin
      bad++; $display("FAIL b2b_count got rsp=%0d acc=%0d want 2 2", n_rsp, n_acc);
    end
    total++;
    if ({rres[0], rz[0], rres[1], rz[1]} !== {16'h0000, 1'b1, 16'h00F0, 1'b0}) begin
      bad++; $display("FAIL b2b_order got %h/%b %h/%b want 0000/1 00f0/0",
                      rres[0], rz[0], rres[1], rz[1]);
    end
    total++;
    if (acc_cyc[1] - acc_cyc[0] !== LAT + 3) begin
      bad++; $display("FAIL b2b_spacing got=%0d want=%0d", acc_cyc[1] - acc_cyc[0], LAT + 3);
    end
    total++;
    if (op_count !== exp_count) begin
      bad++; $display("FAIL b2b_opcount got=%0d want=%0d", op_count, exp_count);
    end
  endtask

  task automatic test_random();
    int e, d;
    logic [2:0] op;
    logic [15:0] a, b;
    logic [3:0] tag;
    logic [25:0] exp_v;
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 16'($urandom);
      b   = 16'($urandom);
      tag = 4'($urandom);
      if (n % 8 == 0) b = a;
      exp_v = ref_rsp(op, a, b, tag);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      total++;
      if (cmd_ready !== 1'b1) begin
        bad++; $display("FAIL rnd_ready n=%0d got=%b want=1", n, cmd_ready);
      end
      send(op, a, b, tag);
      wait_rsp(e);
      total++;
      if (e !== LAT + 1) begin
        bad++; $display("FAIL rnd_latency n=%0d got=%0d want=%0d", n, e, LAT + 1);
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        total++;
        if ({rsp_valid, obs(), alu_A, alu_B, alu_opcode} !== {1'b1, exp_v, a, b, op}) begin
          bad++; $display("FAIL rnd_rsp n=%0d op=%0d a=%h b=%h got vld=%b rsp=%h want rsp=%h",
                          n, op, a, b, rsp_valid, obs(), exp_v);
        end
        if (i < d) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      complete();
      total++;
      if (op_count !== exp_count) begin
        bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, op_count, exp_count);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_tag   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_uadd();
    test_sadd();
    test_sub();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Command-side front end for the registered 16-bit ALU. It accepts one operation at a time over a valid/ready command interface.
- It drives the ALU's A/B/opcode inputs and holds them stable, waits out the ALU's registered latency, then captures result and flags.
- It presents the captured result on a valid/ready response interface, adding negative and signed/unsigned less-than conditions for branch/compare logic.
- It sits between the datapath sequencer and the ALU; the ALU has no reset and no enable, so this block owns operand stability.

Parameters:
- NUMBITS, 16, operand/result width; must match the ALU instance.
- TAGW, 4, width of the opaque command tag returned with each response.
- ALU_LAT, 1, edges from ALU input change until ALU outputs are registered; range 1..7.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode: 000 uadd, 001 sadd, 010 usub, 011 ssub, 100 and, 101 or, 110 xor, 111 A>>1
- cmd_a  in  NUMBITS  operand A
- cmd_b  in  NUMBITS  operand B
- cmd_tag  in  TAGW  caller tag
- alu_A  out  NUMBITS  to ALU A
- alu_B  out  NUMBITS  to ALU B
- alu_opcode  out  3  to ALU opcode
- alu_result  in  NUMBITS  from ALU result
- alu_carryout  in  1  from ALU carryout
- alu_overflow  in  1  from ALU overflow
- alu_zero  in  1  from ALU zero
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  NUMBITS  captured result
- rsp_carry  out  1  captured carryout
- rsp_overflow  out  1  captured overflow
- rsp_zero  out  1  captured zero
- rsp_neg  out  1  rsp_result[NUMBITS-1]
- rsp_lt_u  out  1  unsigned A<B; valid only for op 010
- rsp_lt_s  out  1  signed A<B; valid only for op 011
- rsp_tag  out  TAGW  tag of the command
- op_count  out  16  responses delivered since reset

Behaviour:
- Reset (sync, highest priority, any state, including mid-operation):
  - state IDLE, cmd_ready=1, rsp_valid=0.
  - alu_A, alu_B, alu_opcode = 0.
  - All rsp_* = 0, op_count = 0, latency counter = 0.
  - An in-flight operation is dropped; no response is produced.
- States and transitions:
  - IDLE: cmd_ready=1. On an edge with cmd_valid=1, register cmd_a/cmd_b/cmd_op into alu_A/alu_B/alu_opcode, latch cmd_tag, load cnt=ALU_LAT, go WAIT. With cmd_valid=0, alu_* hold their last values.
  - WAIT: cmd_ready=0. Each edge with cnt!=0 decrements cnt. On the edge with cnt==0, capture alu_result/alu_carryout/alu_overflow/alu_zero into rsp_*, assert rsp_valid, go RESP.
  - RESP: cmd_ready=0, rsp_valid=1. All rsp_* hold unchanged while rsp_ready=0. On an edge with rsp_ready=1: clear rsp_valid, op_count+1 (wraps FFFF->0000), go IDLE.
- Timing:
  - Accept edge E0 -> rsp_valid high after edge E0+ALU_LAT+1. With ALU_LAT=1, rsp_valid is high after E2.
  - Minimum spacing between accepts is ALU_LAT+3 edges.
  - No accept in the same cycle as response completion; cmd_ready rises only after IDLE is re-entered.
- alu_A, alu_B and alu_opcode are stable from the accept edge through the end of RESP.
- Derived flags, registered at the capture edge:
  - rsp_neg = alu_result MSB.
  - rsp_lt_u = alu_carryout when alu_opcode==010 (borrow), else 0.
  - rsp_lt_s = alu_result MSB XOR alu_overflow when alu_opcode==011, else 0.
- Width rules: all datapath fields are NUMBITS wide with no extension or truncation. op_count is fixed at 16 bits.

Test Plan:
1. uadd: A=FFFF, B=0001, tag=3, rsp_ready=1 -> rsp_valid exactly 2 edges after accept (ALU_LAT=1); result=0000, carry=1, zero=1, overflow=0, rsp_tag=3, op_count=1.
2. sadd: A=7FFF, B=0001 -> result=8000, overflow=1, neg=1, carry=0, zero=0.
3. usub: A=0003, B=0005 -> result=FFFE, carry=1, lt_u=1, lt_s=0. Then ssub A=8000, B=0001 -> result=7FFF, overflow=1, neg=0, lt_s=1, lt_u=0.
4. Backpressure: xor A=00FF, B=0F0F, rsp_ready held 0 for 5 cycles -> rsp_valid=1 with result 0FF0 stable all 5 cycles. cmd_ready stays 0 and a cmd_valid presented meanwhile is not taken. After rsp_ready=1: op_count increments once, cmd_ready=1 next cycle.
5. Reset mid-WAIT: accept and A=1234, B=1111, assert reset one cycle later -> next cycle rsp_valid=0, cmd_ready=1, alu_A=0, op_count=0; no response ever appears for the dropped command.
6. Back-to-back with cmd_valid held 1: shift 111 A=0001, then and 100 A=F0F0, B=0FF0 -> responses in order with results 0000 (zero=1) then 00F0 (zero=0). Accepts are spaced ALU_LAT+3 edges apart.
